// File: rtl/rv32_single_cycle_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32_pkg                                                  |
// | Brief    : RV32I-subset encodings, ALU operation enum, helpers       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_single_cycle_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32_single_cycle_core_if                                 |
// | Brief    : Instruction fetch bus between core and instruction ROM    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface rv32_single_cycle_core_if;
    import rv32_pkg::*;

    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;

    modport master (output addr, input  instr);
    modport slave  (input  addr, output instr);
endinterface
`default_nettype wire

// File: rtl/rv32_single_cycle_core_imem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32_imem                                                 |
// | Brief    : Instruction ROM, contents driven from outside, async read |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rv32_imem #(
    parameter int IMEM_DEPTH = 64
) (
    rv32_single_cycle_core_if.slave fetch
);
    import rv32_pkg::*;

    localparam int IW = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] rom_data [0:IMEM_DEPTH-1];

    // Byte address to word index; upper bits dropped so the PC wraps over the ROM
    assign fetch.instr = rom_data[fetch.addr[IW+1:2]];
endmodule
`default_nettype wire

// File: rtl/rv32_single_cycle_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32_single_cycle_core                                    |
// | Brief    : Single-cycle RV32I-subset core with private ROM and RAM   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rv32_single_cycle_core #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic clk,
    input  logic reset
);
    import rv32_pkg::*;

    localparam int DW = $clog2(DMEM_DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] rf   [0:31];
    logic [XLEN-1:0] dmem [0:DMEM_DEPTH-1];

    rv32_single_cycle_core_if u_fetch_if ();
    rv32_imem #(.IMEM_DEPTH(IMEM_DEPTH)) inst_mem (.fetch(u_fetch_if));

    logic [XLEN-1:0] instr;
    assign u_fetch_if.addr = pc;
    assign instr           = u_fetch_if.instr;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    logic            rf_we, dmem_we, is_load, branch_taken;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b, mem_off;

    // Anything not matched below falls through as a NOP with pc+4
    always_comb begin
        rf_we        = 1'b0;
        dmem_we      = 1'b0;
        is_load      = 1'b0;
        branch_taken = 1'b0;
        alu_op       = ALU_ADD;
        alu_b        = rs2_val;
        mem_off      = imm_i;
        case (opcode)
            OP_R: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
                    rf_we  = 1'b1;
                    alu_op = alu_op_from_f3(f3, f7 == F7_ALT);
                end
            end
            OP_I: begin
                if ((f3 == F3_SLL) ? (f7 == F7_BASE) :
                    (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1) begin
                    rf_we  = 1'b1;
                    alu_b  = imm_i;
                    alu_op = alu_op_from_f3(f3, f3 == F3_SR && f7 == F7_ALT);
                end
            end
            OP_LOAD: begin
                if (f3 == F3_LW) begin
                    rf_we   = 1'b1;
                    is_load = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == F3_SW) begin
                    dmem_we = 1'b1;
                    mem_off = imm_s;
                end
            end
            OP_BRANCH: begin
                if (f3 == F3_BEQ)      branch_taken = (rs1_val == rs2_val);
                else if (f3 == F3_BNE) branch_taken = (rs1_val != rs2_val);
            end
            OP_LUI: begin
                rf_we  = 1'b1;
                alu_op = ALU_PASSB;
                alu_b  = imm_u;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:   alu_res = rs1_val + alu_b;
            ALU_SUB:   alu_res = rs1_val - alu_b;
            ALU_SLL:   alu_res = rs1_val << shamt;
            ALU_SLT:   alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            ALU_SLTU:  alu_res = {31'b0, rs1_val < alu_b};
            ALU_XOR:   alu_res = rs1_val ^ alu_b;
            ALU_SRL:   alu_res = rs1_val >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(rs1_val) >>> shamt);
            ALU_OR:    alu_res = rs1_val | alu_b;
            ALU_AND:   alu_res = rs1_val & alu_b;
            ALU_PASSB: alu_res = alu_b;
            default:   alu_res = '0;
        endcase
    end

    logic [XLEN-1:0] mem_addr, wb_val;
    logic [DW-1:0]   dmem_idx;
    assign mem_addr = rs1_val + mem_off;
    assign dmem_idx = mem_addr[DW+1:2];
    assign wb_val   = is_load ? dmem[dmem_idx] : alu_res;
    assign pc_d     = branch_taken ? (pc + imm_b) : (pc + 32'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            for (int i = 0; i < 32; i++)         rf[i]   <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            pc <= pc_d;
            if (rf_we && rd != 5'd0) rf[rd]         <= wb_val;
            if (dmem_we)             dmem[dmem_idx] <= rs2_val;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rv32_single_cycle_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rv32_single_cycle_core                                 |
// | Brief    : Directed program tests for rv32_single_cycle_core         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_rv32_single_cycle_core;

    logic        clk;
    logic        reset;
    logic [31:0] rom [0:63];
    int          total;
    int          bad;

    rv32_single_cycle_core #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset)
    );

    assign dut.inst_mem.rom_data = rom;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int nz;
        clear_rom();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dut.pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=%h", dut.pc, 32'd0); end
        nz = 0;
        for (int i = 1; i < 32; i++) if (dut.rf[i] !== 32'd0) nz++;
        total++;
        if (nz !== 0) begin bad++; $display("FAIL reset_rf nonzero_regs got=%0d want=0", nz); end
        reset = 1'b1;
        run(1);
        total++;
        if (dut.pc !== 32'd4) begin bad++; $display("FAIL reset_release_pc got=%h want=%h", dut.pc, 32'd4); end
    endtask

    task automatic test_alu();
        clear_rom();
        rom[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
        rom[1] = enc_i(12'd3, 5'd0, 3'b000, 5'd2);
        rom[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        rom[3] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4);
        rom[4] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd5);
        do_reset();
        run(5);
        total++;
        if (dut.rf[3] !== 32'd8) begin bad++; $display("FAIL alu_add got=%h want=%h", dut.rf[3], 32'd8); end
        total++;
        if (dut.rf[4] !== 32'd2) begin bad++; $display("FAIL alu_sub got=%h want=%h", dut.rf[4], 32'd2); end
        total++;
        if (dut.rf[5] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL alu_sub_neg got=%h want=%h", dut.rf[5], 32'hFFFF_FFFE); end
        total++;
        if (dut.pc !== 32'd20) begin bad++; $display("FAIL alu_pc got=%h want=%h", dut.pc, 32'd20); end
    endtask

    task automatic test_logic();
        clear_rom();
        rom[0]  = enc_i(12'd12, 5'd0, 3'b000, 5'd1);
        rom[1]  = enc_i(12'd10, 5'd0, 3'b000, 5'd2);
        rom[2]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd3);
        rom[3]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd4);
        rom[4]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd6);
        rom[5]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd7);
        rom[6]  = enc_r(7'b0000000, 5'd1, 5'd6, 3'b010, 5'd8);
        rom[7]  = enc_r(7'b0000000, 5'd1, 5'd6, 3'b011, 5'd9);
        rom[8]  = enc_r(7'b0100000, 5'd2, 5'd6, 3'b101, 5'd10);
        rom[9]  = enc_i(12'd28, 5'd6, 3'b101, 5'd11);
        rom[10] = enc_i(12'd4, 5'd1, 3'b001, 5'd12);
        rom[11] = {20'h12345, 5'd13, 7'b0110111};
        rom[12] = enc_i(12'h400 | 12'd28, 5'd6, 3'b101, 5'd14);
        do_reset();
        run(13);
        total++;
        if (dut.rf[3] !== 32'hE) begin bad++; $display("FAIL logic_or got=%h want=%h", dut.rf[3], 32'hE); end
        total++;
        if (dut.rf[4] !== 32'h8) begin bad++; $display("FAIL logic_and got=%h want=%h", dut.rf[4], 32'h8); end
        total++;
        if (dut.rf[6] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL logic_addi_neg got=%h want=%h", dut.rf[6], 32'hFFFF_FFFF); end
        total++;
        if (dut.rf[7] !== 32'h6) begin bad++; $display("FAIL logic_xor got=%h want=%h", dut.rf[7], 32'h6); end
        total++;
        if (dut.rf[8] !== 32'h1) begin bad++; $display("FAIL logic_slt got=%h want=%h", dut.rf[8], 32'h1); end
        total++;
        if (dut.rf[9] !== 32'h0) begin bad++; $display("FAIL logic_sltu got=%h want=%h", dut.rf[9], 32'h0); end
        total++;
        if (dut.rf[10] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL logic_sra got=%h want=%h", dut.rf[10], 32'hFFFF_FFFF); end
        total++;
        if (dut.rf[11] !== 32'hF) begin bad++; $display("FAIL logic_srli got=%h want=%h", dut.rf[11], 32'hF); end
        total++;
        if (dut.rf[12] !== 32'hC0) begin bad++; $display("FAIL logic_slli got=%h want=%h", dut.rf[12], 32'hC0); end
        total++;
        if (dut.rf[13] !== 32'h1234_5000) begin bad++; $display("FAIL logic_lui got=%h want=%h", dut.rf[13], 32'h1234_5000); end
        total++;
        if (dut.rf[14] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL logic_srai got=%h want=%h", dut.rf[14], 32'hFFFF_FFFF); end
    endtask

    task automatic test_memory();
        clear_rom();
        rom[0] = enc_i(12'd8, 5'd0, 3'b000, 5'd1);
        rom[1] = enc_i(12'h55, 5'd0, 3'b000, 5'd2);
        rom[2] = enc_sw(12'd0, 5'd2, 5'd1);
        rom[3] = enc_lw(12'd0, 5'd1, 5'd7);
        rom[4] = enc_i(12'd3, 5'd1, 3'b000, 5'd1);
        rom[5] = enc_sw(12'd5, 5'd2, 5'd1);
        rom[6] = enc_i(12'd256, 5'd0, 3'b000, 5'd14);
        rom[7] = enc_sw(12'd0, 5'd2, 5'd14);
        do_reset();
        run(8);
        total++;
        if (dut.dmem[2] !== 32'h55) begin bad++; $display("FAIL mem_store got=%h want=%h", dut.dmem[2], 32'h55); end
        total++;
        if (dut.rf[7] !== 32'h55) begin bad++; $display("FAIL mem_load got=%h want=%h", dut.rf[7], 32'h55); end
        total++;
        if (dut.rf[1] !== 32'd11) begin bad++; $display("FAIL mem_addi_after_load got=%h want=%h", dut.rf[1], 32'd11); end
        total++;
        if (dut.dmem[4] !== 32'h55) begin bad++; $display("FAIL mem_unaligned_store got=%h want=%h", dut.dmem[4], 32'h55); end
        total++;
        if (dut.dmem[0] !== 32'h55) begin bad++; $display("FAIL mem_wrap_store got=%h want=%h", dut.dmem[0], 32'h55); end
        total++;
        if (dut.dmem[3] !== 32'h0) begin bad++; $display("FAIL mem_untouched got=%h want=%h", dut.dmem[3], 32'h0); end
    endtask

    task automatic test_zero();
        clear_rom();
        rom[0] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1);
        rom[1] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1);
        rom[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1);
        rom[3] = enc_i(12'd7, 5'd0, 3'b000, 5'd0);
        rom[4] = enc_i(12'd1, 5'd0, 3'b000, 5'd5);
        do_reset();
        run(5);
        total++;
        if (dut.rf[1] !== 32'd0) begin bad++; $display("FAIL zero_add got=%h want=%h", dut.rf[1], 32'd0); end
        total++;
        if (dut.rf[0] !== 32'd0) begin bad++; $display("FAIL zero_x0_write got=%h want=%h", dut.rf[0], 32'd0); end
        total++;
        if (dut.rf[5] !== 32'd1) begin bad++; $display("FAIL zero_x0_read got=%h want=%h", dut.rf[5], 32'd1); end
        total++;
        if (dut.pc !== 32'd20) begin bad++; $display("FAIL zero_pc got=%h want=%h", dut.pc, 32'd20); end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [0:8];
        clear_rom();
        rom[0]  = enc_i(12'd4, 5'd0, 3'b000, 5'd1);
        rom[1]  = enc_i(12'd4, 5'd0, 3'b000, 5'd2);
        rom[2]  = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
        rom[3]  = enc_i(12'd1, 5'd0, 3'b000, 5'd10);
        rom[4]  = enc_b(13'd8, 5'd2, 5'd1, 3'b001);
        rom[5]  = 32'h0000_0000;
        rom[6]  = enc_b(13'd8, 5'd0, 5'd1, 3'b000);
        rom[7]  = enc_b(13'd12, 5'd0, 5'd1, 3'b001);
        rom[10] = enc_i(12'd7, 5'd0, 3'b000, 5'd11);
        rom[11] = enc_b(13'h1FD4, 5'd0, 5'd0, 3'b000);
        exp_pc = '{32'd4, 32'd8, 32'd16, 32'd20, 32'd24, 32'd28, 32'd40, 32'd44, 32'd0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run(1);
            total++;
            if (dut.pc !== exp_pc[i]) begin
                bad++;
                $display("FAIL branch_pc step=%0d got=%h want=%h", i, dut.pc, exp_pc[i]);
            end
        end
        total++;
        if (dut.rf[10] !== 32'd0) begin bad++; $display("FAIL branch_skipped got=%h want=%h", dut.rf[10], 32'd0); end
        total++;
        if (dut.rf[11] !== 32'd7) begin bad++; $display("FAIL branch_target got=%h want=%h", dut.rf[11], 32'd7); end
    endtask

    task automatic test_reset_midrun();
        clear_rom();
        rom[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
        do_reset();
        run(3);
        total++;
        if (dut.rf[1] !== 32'd5 || dut.pc !== 32'd12) begin
            bad++;
            $display("FAIL midrun_pre got=%h/%h want=%h/%h", dut.rf[1], dut.pc, 32'd5, 32'd12);
        end
        reset = 1'b0;
        #1;
        total++;
        if (dut.pc !== 32'd0 || dut.rf[1] !== 32'd0) begin
            bad++;
            $display("FAIL midrun_async got=%h/%h want=%h/%h", dut.pc, dut.rf[1], 32'd0, 32'd0);
        end
        run(2);
        total++;
        if (dut.pc !== 32'd0) begin bad++; $display("FAIL midrun_hold got=%h want=%h", dut.pc, 32'd0); end
        reset = 1'b1;
        run(1);
        total++;
        if (dut.pc !== 32'd4) begin bad++; $display("FAIL midrun_release got=%h want=%h", dut.pc, 32'd4); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        clear_rom();
        test_reset();
        test_alu();
        test_logic();
        test_memory();
        test_zero();
        test_branch();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
